// File: rtl/key_filter_pkg.sv
// Shared constants for the multi-channel key debouncer: one-hot FSM encodings,
// output reset levels and a small helper for sizing the shared counter.
package key_filter_pkg;

  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_FILTER0 = 4'b0010;
  localparam logic [3:0] ST_DOWN    = 4'b0100;
  localparam logic [3:0] ST_FILTER1 = 4'b1000;

  // Released level; sync/edge flops also preset here so reset exit is quiet
  localparam logic KEY_STATE_RST = 1'b1;
  localparam logic KEY_FLAG_RST  = 1'b0;
  localparam logic KEY_LONG_RST  = 1'b0;
  localparam logic SYNC_RST      = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One debounce channel: 2-flop synchroniser, edge detector, 4-state debounce FSM
// and a shared counter used for both the debounce window and the long-press timer.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int unsigned CNT_MAX  = 1_000_000,
  parameter int unsigned LONG_MAX = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_flag,
  output logic key_long
);

  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_MAX - 1);

  logic s1, s2, s3;
  logic neg, pos;

  logic [3:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             long_done, long_done_nxt;
  logic             key_state_nxt, key_flag_nxt, key_long_nxt;

  // Synchroniser and edge register, preset to the released level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= SYNC_RST;
      s2 <= SYNC_RST;
      s3 <= SYNC_RST;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign neg = s3 & ~s2;
  assign pos = ~s3 & s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      long_done <= 1'b0;
      key_state <= KEY_STATE_RST;
      key_flag  <= KEY_FLAG_RST;
      key_long  <= KEY_LONG_RST;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      long_done <= long_done_nxt;
      key_state <= key_state_nxt;
      key_flag  <= key_flag_nxt;
      key_long  <= key_long_nxt;
    end
  end

  // Next-state and output logic; an edge always beats a terminal count
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    long_done_nxt = long_done;
    key_state_nxt = key_state;
    key_flag_nxt  = 1'b0;
    key_long_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (neg) state_nxt = ST_FILTER0;
      end
      ST_FILTER0: begin
        if (pos) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_END) begin
          state_nxt     = ST_DOWN;
          cnt_nxt       = '0;
          long_done_nxt = 1'b0;
          key_state_nxt = 1'b0;
          key_flag_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_DOWN: begin
        if (pos) begin
          state_nxt = ST_FILTER1;
          cnt_nxt   = '0;
        end else if (cnt == LONG_END) begin
          // Counter saturates; long_done keeps the pulse to a single cycle
          if (!long_done) begin
            key_long_nxt  = 1'b1;
            long_done_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_FILTER1: begin
        if (neg) begin
          state_nxt     = ST_DOWN;
          cnt_nxt       = '0;
          long_done_nxt = 1'b0;
        end else if (cnt == CNT_END) begin
          state_nxt     = ST_IDLE;
          cnt_nxt       = '0;
          key_state_nxt = 1'b1;
          key_flag_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        cnt_nxt       = '0;
        long_done_nxt = 1'b0;
        key_state_nxt = KEY_STATE_RST;
      end
    endcase
  end

endmodule

// File: rtl/key_filter_multi.sv
// Multi-channel push-button debouncer: NUM_KEYS independent key_filter_ch
// instances sharing one clock and reset.
module key_filter_multi
  import key_filter_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned CNT_MAX  = 1_000_000,
  parameter int unsigned LONG_MAX = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_flag,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int unsigned CNT_W = $clog2(max_u(CNT_MAX, LONG_MAX));

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_filter_ch #(
      .CNT_MAX (CNT_MAX),
      .LONG_MAX(LONG_MAX),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_in   (key_in[i]),
      .key_state(key_state[i]),
      .key_flag (key_flag[i]),
      .key_long (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Scoreboard bench for key_filter_multi: stimulus queues expected flag/long
// events with their cycle stamps, a monitor pops and compares them as they occur.
module tb_key_filter_multi;

  localparam int unsigned NK = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state, key_flag, key_long;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    bit is_long;
    int ch;
    bit level;
  } ev_t;

  ev_t exp_q[$];

  key_filter_multi #(
    .NUM_KEYS(NK),
    .CNT_MAX (20),
    .LONG_MAX(100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_state(key_state),
    .key_flag (key_flag),
    .key_long (key_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int c, input bit is_long, input int ch, input bit level);
    ev_t e;
    e.cyc     = c;
    e.is_long = is_long;
    e.ch      = ch;
    e.level   = level;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input bit is_long, input int ch);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got ch=%0d long=%0d at cyc=%0d, expected no event",
               ch, is_long, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.is_long != is_long || e.ch != ch ||
          (!is_long && key_state[ch] !== e.level)) begin
        failures++;
        $display("FAIL event: got cyc=%0d ch=%0d long=%0d level=%b, expected cyc=%0d ch=%0d long=%0d level=%b",
                 cyc, ch, is_long, key_state[ch], e.cyc, e.ch, e.is_long, e.level);
      end
    end
  endtask

  // Monitor: every asserted pulse must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < int'(NK); ch++) begin
        if (key_flag[ch]) check_ev(1'b0, ch);
        if (key_long[ch]) check_ev(1'b1, ch);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int g;
    rst_n  = 1'b0;
    key_in = '1;
    wait_cyc(3);
    chk("reset_state", key_state, 4'hF);
    chk("reset_flag", key_flag, 4'h0);
    chk("reset_long", key_long, 4'h0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Clean press held 60 cycles, then release
    key_in[0] = 1'b0;
    push_ev(cyc + 23, 1'b0, 0, 1'b0);
    wait_cyc(30);
    chk("clean_held", key_state, 4'hE);
    wait_cyc(30);
    key_in[0] = 1'b1;
    push_ev(cyc + 23, 1'b0, 0, 1'b1);
    wait_cyc(40);
    chk("clean_released", key_state, 4'hF);

    // Bouncing press: toggles every 5 cycles, then settles low
    for (int i = 0; i < 6; i++) begin
      key_in[0] = i[0];
      wait_cyc(5);
    end
    key_in[0] = 1'b0;
    push_ev(cyc + 23, 1'b0, 0, 1'b0);
    wait_cyc(40);
    chk("bounce_held", key_state, 4'hE);
    key_in[0] = 1'b1;
    push_ev(cyc + 23, 1'b0, 0, 1'b1);
    wait_cyc(40);

    // Long hold: one long pulse 100 cycles after the confirm flag
    key_in[0] = 1'b0;
    push_ev(cyc + 23, 1'b0, 0, 1'b0);
    push_ev(cyc + 123, 1'b1, 0, 1'b0);
    wait_cyc(150);
    key_in[0] = 1'b1;
    push_ev(cyc + 23, 1'b0, 0, 1'b1);
    wait_cyc(40);
    chk("long_released", key_state, 4'hF);

    // Release glitch while DOWN restarts the long-press count
    key_in[0] = 1'b0;
    push_ev(cyc + 23, 1'b0, 0, 1'b0);
    wait_cyc(40);
    key_in[0] = 1'b1;
    g = cyc;
    wait_cyc(4);
    chk("glitch_state", key_state, 4'hE);
    wait_cyc(8 - (cyc - g));
    key_in[0] = 1'b0;
    push_ev(cyc + 103, 1'b1, 0, 1'b0);
    wait_cyc(110);
    chk("glitch_held", key_state, 4'hE);
    key_in[0] = 1'b1;
    push_ev(cyc + 23, 1'b0, 0, 1'b1);
    wait_cyc(40);

    // Keys 1 and 3 together; key 2 released mid-filter
    key_in[3:1] = 3'b000;
    push_ev(cyc + 23, 1'b0, 1, 1'b0);
    push_ev(cyc + 23, 1'b0, 3, 1'b0);
    wait_cyc(10);
    key_in[2] = 1'b1;
    wait_cyc(30);
    chk("multi_state", key_state, 4'b0101);
    key_in[3] = 1'b1;
    push_ev(cyc + 23, 1'b0, 3, 1'b1);
    wait_cyc(30);
    chk("multi_rel3", key_state, 4'b1101);

    // Async reset with key 0 in FILTER0 and key 1 DOWN
    key_in[0] = 1'b0;
    wait_cyc(10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", key_state, 4'hF);
    chk("async_rst_flag", key_flag, 4'h0);
    chk("async_rst_long", key_long, 4'h0);
    key_in[0] = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    push_ev(cyc + 23, 1'b0, 1, 1'b0);
    wait_cyc(40);
    chk("post_rst_state", key_state, 4'b1101);
    key_in[1] = 1'b1;
    push_ev(cyc + 23, 1'b0, 1, 1'b1);
    wait_cyc(40);
    chk("final_state", key_state, 4'hF);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d unconsumed, expected 0 (next cyc=%0d ch=%0d)",
               exp_q.size(), exp_q[0].cyc, exp_q[0].ch);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
